// File: rtl/alu_seq.sv
// Registered multi-op ALU with a C/Z/N/V flags register loaded under fi.
// Define ALU_SHIFT_EN to build the iterative one-bit-per-cycle SHL/SHR path.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             fi,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             busy,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v;
  logic             ld;

  // Single-cycle result; opcodes 11x pass a through and become shifts only
  // when the iterative path is built and the amount is non-zero.
  always_comb begin
    ext   = '0;
    alu_v = 1'b0;
    case (op)
      OP_ADD:  ext = {1'b0, a} + {1'b0, b};
      OP_SUB:  ext = {1'b0, a} - {1'b0, b};
      OP_ADC:  ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_q};
      OP_SBB:  ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c_q};
      OP_AND:  ext = {1'b0, a & b};
      OP_OR:   ext = {1'b0, a | b};
      default: ext = {1'b0, a};
    endcase
    case (op)
      OP_ADD, OP_ADC: alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      OP_SUB, OP_SBB: alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      default:        alu_v = 1'b0;
    endcase
    alu_r = ext[WIDTH-1:0];
    alu_c = ext[WIDTH];
  end

`ifdef ALU_SHIFT_EN
  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_step;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             fi_q, fi_d;
  logic             sh_bit;

  always_comb begin
    if (dir_q) begin
      sh_step = sh_q >> 1;
      sh_bit  = sh_q[0];
    end else begin
      sh_step = sh_q << 1;
      sh_bit  = sh_q[WIDTH-1];
    end
  end

  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    ld      = 1'b0;
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    fi_d    = fi_q;
    if (state_q == S_SHIFT) begin
      sh_d  = sh_step;
      cnt_d = cnt_q - SHW'(1);
      if (cnt_q == SHW'(1)) begin
        out_d   = sh_step;
        valid_d = 1'b1;
        state_d = S_IDLE;
        if (fi_q) begin
          c_d = sh_bit;
          z_d = (sh_step == '0);
          n_d = sh_step[WIDTH-1];
          v_d = 1'b0;
        end
      end
    end else if (start) begin
      if (op[2:1] == 2'b11 && b[SHW-1:0] != '0) begin
        sh_d    = a;
        cnt_d   = b[SHW-1:0];
        dir_d   = op[0];
        fi_d    = fi;
        state_d = S_SHIFT;
      end else begin
        ld = 1'b1;
      end
    end
    if (ld) begin
      out_d   = alu_r;
      valid_d = 1'b1;
      if (fi) begin
        c_d = alu_c;
        z_d = (alu_r == '0);
        n_d = alu_r[WIDTH-1];
        v_d = alu_v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      fi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      fi_q    <= fi_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
`else
  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    ld      = start;
    if (ld) begin
      out_d   = alu_r;
      valid_d = 1'b1;
      if (fi) begin
        c_d = alu_c;
        z_d = (alu_r == '0);
        n_d = alu_r[WIDTH-1];
        v_d = alu_v;
      end
    end
  end

  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

  assign out      = out_q;
  assign valid    = valid_q;
  assign carry    = c_q;
  assign zero     = z_q;
  assign negative = n_q;
  assign overflow = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases plus random ops against an integer model.
// Expectations follow ALU_SHIFT_EN the same way the design build does.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic         fi = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] out;
  logic         valid, busy, carry, zero, negative, overflow;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference state: last result and flags register.
  int m_out;
  bit mc, mz, mn, mv;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .fi(fi), .a(a), .b(b),
    .out(out), .valid(valid), .busy(busy), .carry(carry), .zero(zero),
    .negative(negative), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit shifts_on();
`ifdef ALU_SHIFT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model(input int o, input int x, input int y,
                                output int r, output bit c, output bit v);
    int cin, sx, sy, u, s, n;
    cin = mc ? 1 : 0;
    sx  = (x >= 128) ? x - 256 : x;
    sy  = (y >= 128) ? y - 256 : y;
    n   = y % 8;
    u = 0; s = 0; c = 0; v = 0; r = x;
    case (o)
      0, 2: begin
        u = x + y + ((o == 2) ? cin : 0);
        s = sx + sy + ((o == 2) ? cin : 0);
        r = u % 256; c = (u > 255); v = (s > 127 || s < -128);
      end
      1, 3: begin
        u = x - y - ((o == 3) ? cin : 0);
        s = sx - sy - ((o == 3) ? cin : 0);
        r = (u + 512) % 256; c = (u < 0); v = (s > 127 || s < -128);
      end
      4: r = x & y;
      5: r = x | y;
      6: if (shifts_on()) begin
        r = (x * (1 << n)) % 256;
        c = (n > 0) ? ((x >> (8 - n)) & 1) : 0;
      end
      default: if (shifts_on()) begin
        r = x >> n;
        c = (n > 0) ? ((x >> (n - 1)) & 1) : 0;
      end
    endcase
  endfunction

  task automatic do_op(input int o, input int x, input int y, input bit f);
    int r, lat;
    bit c, v;
    model(o, x, y, r, c, v);
    lat = (shifts_on() && o >= 6) ? (y % 8) : 0;
    m_out = r;
    if (f) begin
      mc = c; mz = (r == 0); mn = (r >= 128); mv = v;
    end
    @(negedge clk);
    op = 3'(o); a = W'(x); b = W'(y); fi = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); a = W'($urandom); b = W'($urandom); fi = 1'($urandom);
    if (lat == 0) begin
      check("valid_e0", valid, 1);
      check("busy_e0", busy, 0);
    end else begin
      check("busy_e0", busy, 1);
      check("novalid_e0", valid, 0);
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        start = 1'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        if (k < lat) begin
          check("busy_mid", busy, 1);
          check("novalid_mid", valid, 0);
        end else begin
          check("valid_en", valid, 1);
          check("busy_en", busy, 0);
        end
      end
    end
    check("out", out, 32'(m_out));
    check("flags", {carry, zero, negative, overflow}, {mc, mz, mn, mv});
    @(posedge clk); #1;
    check("valid_pulse", valid, 0);
    check("out_hold", out, 32'(m_out));
  endtask

  initial begin
    m_out = 0; mc = 0; mz = 0; mn = 0; mv = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, 0);
    check("rst_flags", {carry, zero, negative, overflow}, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle_valid", valid, 0);

    do_op(0, 'hF0, 'h20, 1);
    check("t1_out", out, 'h10);  check("t1_flags", {carry, zero, negative, overflow}, 4'b1000);
    do_op(1, 'h05, 'h05, 1);
    check("t2a_out", out, 'h00); check("t2a_flags", {carry, zero, negative, overflow}, 4'b0100);
    do_op(1, 'h03, 'h05, 1);
    check("t2b_out", out, 'hFE); check("t2b_flags", {carry, zero, negative, overflow}, 4'b1010);
    do_op(0, 'hFF, 'h01, 1);
    check("t3a_flags", {carry, zero, negative, overflow}, 4'b1100);
    do_op(2, 'h00, 'h00, 1);
    check("t3b_out", out, 'h01); check("t3b_flags", {carry, zero, negative, overflow}, 4'b0000);
    do_op(0, 'h7F, 'h01, 1);
    check("t3c_out", out, 'h80); check("t3c_flags", {carry, zero, negative, overflow}, 4'b0011);
    do_op(0, 'h01, 'h01, 0);
    check("t3d_out", out, 'h02); check("t3d_flags", {carry, zero, negative, overflow}, 4'b0011);
    do_op(6, 'h60, 'h02, 1);
`ifdef ALU_SHIFT_EN
    check("t4_out", out, 'h80); check("t4_flags", {carry, zero, negative, overflow}, 4'b1010);
`else
    check("t4_out", out, 'h60); check("t4_flags", {carry, zero, negative, overflow}, 4'b0000);
`endif
    do_op(7, 'h81, 'h00, 1);
    do_op(6, 'hFF, 'h07, 1);

    repeat (150) do_op(int'($urandom % 8), int'($urandom % 256), int'($urandom % 256), 1'($urandom));

    // Reset asserted one cycle into an op (mid-shift when shifts are built).
    @(negedge clk);
    op = 3'b111; a = 'hFF; b = 'h07; fi = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    m_out = 0; mc = 0; mz = 0; mn = 0; mv = 0;
    check("mr_out", out, 0);
    check("mr_flags", {carry, zero, negative, overflow}, 0);
    check("mr_busy", busy, 0);
    check("mr_valid", valid, 0);
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1 check("mr_novalid", valid, 0);
    end
    do_op(0, 'h01, 'h01, 1);
    check("post_rst_out", out, 'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
